act_requant: RTL
================

# act_requant

Post-MMU activation and requantization stage. Pops one SIZE×SIZE tile of 32-bit accumulator results from the MMU output tile FIFO and adds a per-column bias. It then applies optional ReLU, arithmetic right shift and saturation to signed 8 bits, and pushes the resulting int8 tile into a downstream tile FIFO, typically the next layer's data FIFO.

## Interface
- `SIZE`, 2: tile dimension; must match the MMU array.
- `SHIFT_W`, 5: width of the shift amount.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request processing of one tile.
- `start_rdy` out 1: `start` will be accepted this cycle.
- `done` out 1: one-cycle pulse after the tile is pushed.
- `acc_in[SIZE][SIZE]` in 32 each: source FIFO head, signed.
- `acc_in_rdy` in 1: source FIFO non-empty.
- `acc_in_pop` out 1: pop source FIFO.
- `bias[SIZE]` in 32 each: signed per-column bias.
- `shift` in `SHIFT_W`: right-shift amount, 0..31.
- `relu_en` in 1: clamp negative values to 0.
- `act_out[SIZE][SIZE]` out 8 each: result tile, signed.
- `act_out_rdy` in 1: sink FIFO not full.
- `act_out_push` out 1: push to sink FIFO.

## Operation
- **Start acceptance**
  - `start_rdy` = (state == IDLE) && `acc_in_rdy`.
  - `start` is accepted only when `start_rdy` is high; otherwise it is ignored.
  - On acceptance, `bias`, `shift` and `relu_en` are latched. Later changes have no effect until the next accepted `start`.
- **States**
  - IDLE → POP on accepted `start`.
  - POP → WAIT. `acc_in_pop`=1 for exactly one cycle.
  - WAIT → LOAD. Covers the FIFO output-register latency.
  - LOAD → PROC. All `acc_in` elements are captured into an internal tile register.
  - PROC: a row counter runs 0..SIZE-1, processing one row (all SIZE columns) per cycle. After row SIZE-1 → PUSH.
  - PUSH: `act_out_push` = `act_out_rdy`. Stays in PUSH until `act_out_rdy`=1, then → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
  - Any unused encoding → IDLE.
- **Per-element arithmetic** (row r, column c)
  - s = sext(acc[r][c]) + sext(bias[c]), computed at 34 bits; no overflow is possible.
  - If `relu_en` and s<0, then s=0.
  - If shift>0 and rounding is enabled, s = s + 2^(shift-1).
  - q = s >>> shift (arithmetic shift).
  - out = q saturated to [-128, 127].
- **Output stability:** `act_out[r]` is written only during PROC row r. `act_out` holds its value through PUSH, DONE and IDLE until the next PROC.
- **Reset:** asynchronous and effective mid-operation.
  - Returns to IDLE; the row counter and latched config are cleared.
  - `acc_in_pop`, `act_out_push` and `done` go to 0 immediately.
  - `act_out` is cleared to all zeros. A partially processed tile is discarded and never pushed.
  - A pop already issued is not undone.

## Timing
- **Reset values:** `start_rdy`=`acc_in_rdy` (state IDLE); `done`=0; `acc_in_pop`=0; `act_out_push`=0; `act_out`=0.
- **Accepted `start` at cycle T:**
  - POP with `acc_in_pop`=1 at T+1.
  - WAIT at T+2.
  - LOAD samples `acc_in` at T+3.
  - PROC at T+4..T+3+SIZE.
  - PUSH at T+4+SIZE.
- **Push and done:** with `act_out_rdy` held high, `act_out_push`=1 at T+4+SIZE and `done`=1 at T+5+SIZE. Minimum throughput is one tile per SIZE+6 cycles.
- **Back-to-back:** `start` may be accepted in the IDLE cycle directly after DONE.
- **Backpressure:** `act_out_push` is never asserted while `act_out_rdy`=0. The push happens in the first PUSH cycle with `act_out_rdy`=1.
- **Protocol pulses:**
  - `acc_in_pop` is asserted exactly once per accepted `start`.
  - `act_out_push` is asserted exactly once per tile.
  - Neither is asserted outside POP or PUSH respectively.

## Configuration
- Macro: `ACT_REQUANT_ROUND_EN`.
- **Defined:** round-half-up. 2^(shift-1) is added before the shift when shift>0.
- **Undefined:** truncation toward −∞ (plain arithmetic shift). The rounding adder is not built.

## Test plan
Scenarios use SIZE=2; tiles are written row-major.
- **Saturation, no bias:** `acc_in`=[[100,-100],[1000,-7]], bias=[0,0], shift=0, relu off → `act_out`=[[100,-100],[127,-7]]. `acc_in_pop` is high at T+1 only; push at T+6; done at T+7.
- **ReLU:** `acc_in`=[[-5,5],[-300,300]], relu on, shift=0 → [[0,5],[0,127]]. Also -1000 with relu off → -128.
- **Rounding:** shift=2, `acc_in`=[[6,5],[-6,-5]], bias 0.
  - With `ACT_REQUANT_ROUND_EN` → [[2,1],[-1,-1]].
  - Without → [[1,1],[-2,-2]].
- **Bias and config latching:** bias=[10,-20] at `start`, changed to [0,0] at T+1; `acc_in`=[[0,0],[5,25]] → [[10,-20],[15,5]].
- **Backpressure:** `act_out_rdy`=0 for 5 cycles from T+6 → `act_out_push` stays 0 and `act_out` is stable. When `act_out_rdy` rises at T+11, push=1 at T+11 and done=1 at T+12.
- **Reset and gating:**
  - Assert `rst_n`=0 during PROC → all outputs 0 and no push occurs.
  - After release, `start`=1 with `acc_in_rdy`=0 → ignored; `acc_in_pop` stays 0.

Source files
------------

// File: rtl/act_requant.sv
// Post-MMU requantization: bias add, optional ReLU, arithmetic shift and int8 saturation of one tile.
// Build option: define ACT_REQUANT_ROUND_EN for round-half-up before the shift (default truncates).
module act_requant #(
  parameter int SIZE    = 2,
  parameter int SHIFT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                start_rdy,
  output logic                done,
  input  logic signed [31:0]  acc_in [SIZE][SIZE],
  input  logic                acc_in_rdy,
  output logic                acc_in_pop,
  input  logic signed [31:0]  bias [SIZE],
  input  logic [SHIFT_W-1:0]  shift,
  input  logic                relu_en,
  output logic signed [7:0]   act_out [SIZE][SIZE],
  input  logic                act_out_rdy,
  output logic                act_out_push,
  output logic [2:0]          state_dbg
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_PROC = 3'd4,
    S_PUSH = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic signed [31:0] tile   [SIZE][SIZE];
  logic signed [31:0] bias_q [SIZE];
  logic [SHIFT_W-1:0] shift_q;
  logic               relu_q;
  logic               start_acc;

  // Handshake: start is taken only on a cycle where start && start_rdy; acc_in_pop is a
  // single-cycle pop of the source FIFO; act_out_push fires only while act_out_rdy is high.
  assign start_rdy = (state == S_IDLE) && acc_in_rdy;
  assign start_acc = start && start_rdy;
  assign state_dbg = state;

  // 34-bit sum cannot overflow; the rounding term is added after ReLU so ReLU'd zeros stay zero.
  function automatic logic signed [7:0] requant(
    input logic signed [31:0]  acc,
    input logic signed [31:0]  b,
    input logic [SHIFT_W-1:0]  sh,
    input logic                relu
  );
    logic signed [33:0] s;
    logic signed [33:0] q;
    s = {{2{acc[31]}}, acc} + {{2{b[31]}}, b};
    if (relu && s[33]) s = '0;
`ifdef ACT_REQUANT_ROUND_EN
    if (sh != '0) s = s + (34'sd1 <<< (sh - SHIFT_W'(1)));
`endif
    q = s >>> sh;
    if (q > 34'sd127)       return 8'h7f;
    else if (q < -34'sd128) return 8'h80;
    else                    return q[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    acc_in_pop   = 1'b0;
    act_out_push = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: if (start_acc) state_nxt = S_POP;
      S_POP: begin
        acc_in_pop = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_PROC;
      S_PROC: if (row_cnt == ROW_W'(SIZE - 1)) state_nxt = S_PUSH;
      S_PUSH: begin
        act_out_push = act_out_rdy;
        if (act_out_rdy) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Config is captured at acceptance so later input changes cannot disturb a tile in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      relu_q  <= 1'b0;
      for (int c = 0; c < SIZE; c++) bias_q[c] <= '0;
    end else if (start_acc) begin
      shift_q <= shift;
      relu_q  <= relu_en;
      for (int c = 0; c < SIZE; c++) bias_q[c] <= bias[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) tile[r][c] <= '0;
    end else if (state == S_LOAD) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) tile[r][c] <= acc_in[r][c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
    end else if (state == S_PROC) begin
      if (row_cnt == ROW_W'(SIZE - 1)) row_cnt <= '0;
      else                             row_cnt <= row_cnt + ROW_W'(1);
    end else begin
      row_cnt <= '0;
    end
  end

  // One output row per PROC cycle; act_out otherwise holds until the next tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++) act_out[r][c] <= '0;
    end else if (state == S_PROC) begin
      for (int c = 0; c < SIZE; c++)
        act_out[row_cnt][c] <= requant(tile[row_cnt][c], bias_q[c], shift_q, relu_q);
    end
  end

endmodule
